// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter: state encoding, FSM state type
// and the register map of the control/status slave.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } apb_state_t;

  localparam logic [7:0] REG_CONTROL_0 = 8'h00;
  localparam logic [7:0] REG_CONTROL_1 = 8'h10;
  localparam logic [7:0] REG_STATUS    = 8'h20;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward, wrapping modulo
// NREQ, and grants the first unmasked request.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [NREQ-1:0] eligible;
  int unsigned     idx;

  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    idx      = 0;
    eligible = req & ~mask;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld      = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3-style master sharing one register slave among NREQ requesters with
// round-robin arbitration and fixed two-cycle SETUP/ACCESS transfers.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata
);

  localparam int IW = $clog2(NREQ);

  apb_state_t      state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr_adv;
  logic [IW-1:0]   arb_ptr;
  logic [IW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_mask;
  logic [NREQ-1:0] arb_grant;
  logic            arb_vld;
  logic            launch;

  assign ptr_adv = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

  // On the ACCESS exit edge the finishing winner is masked and the search
  // already starts from the advanced pointer, so back-to-back grants are fair.
  always_comb begin
    arb_mask = '0;
    arb_ptr  = ptr;
    if (state == S_ACCESS) begin
      arb_mask[win_idx] = 1'b1;
      arb_ptr           = ptr_adv;
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req     (req),
    .mask    (arb_mask),
    .ptr     (arb_ptr),
    .grant   (arb_grant),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign launch = arb_vld && (state == S_IDLE || state == S_ACCESS);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (launch) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = launch ? S_SETUP : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= S_IDLE;
      ptr     <= '0;
      win_idx <= '0;
      ack     <= '0;
      rdata   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt != S_IDLE);
      penable <= (state_nxt == S_ACCESS);
      ack     <= '0;
      if (state == S_ACCESS) begin
        ack <= arb_mask;
        ptr <= ptr_adv;
        if (!pwrite) rdata <= prdata;
      end
      // Command fields are sampled only here; later request changes are ignored.
      if (launch) begin
        win_idx <= arb_idx;
        pwrite  <= req_write[arb_idx];
        paddr   <= req_addr[int'(arb_idx)*AW +: AW];
        pwdata  <= req_wdata[int'(arb_idx)*DW +: DW];
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small control/status slave model.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy, psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;

  logic [DW-1:0] ctrl0, ctrl1, status;
  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  // Register slave: read data registered on the SETUP edge, writes on ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl0  <= 32'hDEADBEEF;
      ctrl1  <= 32'h0;
      prdata <= 32'h0;
    end else begin
      if (psel && !penable) begin
        case (paddr)
          REG_CONTROL_0: prdata <= ctrl0;
          REG_CONTROL_1: prdata <= ctrl1;
          REG_STATUS:    prdata <= status;
          default:       prdata <= 32'h0;
        endcase
      end
      if (psel && penable && pwrite) begin
        case (paddr)
          REG_CONTROL_0: ctrl0 <= pwdata;
          REG_CONTROL_1: ctrl1 <= pwdata;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = addr;
    req_wdata[i*DW +: DW]  = wd;
  endtask

  initial begin
    presetn   = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    status    = 32'hA5A50001;
    tick();
    tick();
    chk("rst_psel", {31'b0, psel}, 32'h0);
    chk("rst_penable", {31'b0, penable}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ack", {30'b0, ack}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_paddr", {24'b0, paddr}, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'h0);
    presetn = 1'b1;
    tick();

    // Single read by requester 0
    set_cmd(0, 1'b0, REG_CONTROL_0, 32'h0);
    req = 2'b01;
    tick();
    chk("t1_setup_psel", {31'b0, psel}, 32'h1);
    chk("t1_setup_penable", {31'b0, penable}, 32'h0);
    chk("t1_setup_busy", {31'b0, busy}, 32'h1);
    chk("t1_setup_ack", {30'b0, ack}, 32'h0);
    tick();
    chk("t1_access_penable", {31'b0, penable}, 32'h1);
    chk("t1_access_psel", {31'b0, psel}, 32'h1);
    tick();
    chk("t1_ack", {30'b0, ack}, 32'h1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_idle_psel", {31'b0, psel}, 32'h0);
    req = 2'b00;
    tick();
    chk("t1_ack_pulse", {30'b0, ack}, 32'h0);
    chk("t1_idle_busy", {31'b0, busy}, 32'h0);

    // Write then read of control_1 by requester 1
    set_cmd(1, 1'b1, REG_CONTROL_1, 32'h12345678);
    req = 2'b10;
    tick();
    chk("t2_wr_pwrite", {31'b0, pwrite}, 32'h1);
    chk("t2_wr_paddr", {24'b0, paddr}, 32'h10);
    chk("t2_wr_pwdata", pwdata, 32'h12345678);
    tick();
    tick();
    chk("t2_wr_ack", {30'b0, ack}, 32'h2);
    chk("t2_rdata_hold", rdata, 32'hDEADBEEF);
    set_cmd(1, 1'b0, REG_CONTROL_1, 32'h0);
    tick();
    chk("t2_rd_psel", {31'b0, psel}, 32'h1);
    chk("t2_rd_pwrite", {31'b0, pwrite}, 32'h0);
    tick();
    tick();
    chk("t2_rd_ack", {30'b0, ack}, 32'h2);
    chk("t2_rd_rdata", rdata, 32'h12345678);
    chk("t2_slave_ctrl1", ctrl1, 32'h12345678);
    req = 2'b00;
    tick();

    // Simultaneous requests from reset: back-to-back 0 then 1
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    set_cmd(0, 1'b0, REG_CONTROL_0, 32'h0);
    set_cmd(1, 1'b0, REG_STATUS, 32'h0);
    req = 2'b11;
    tick();
    chk("t3_g0_paddr", {24'b0, paddr}, 32'h00);
    chk("t3_g0_pen", {31'b0, penable}, 32'h0);
    tick();
    chk("t3_g0_pen1", {31'b0, penable}, 32'h1);
    tick();
    chk("t3_ack0", {30'b0, ack}, 32'h1);
    chk("t3_rdata0", rdata, 32'hDEADBEEF);
    chk("t3_b2b_psel", {31'b0, psel}, 32'h1);
    chk("t3_b2b_pen", {31'b0, penable}, 32'h0);
    chk("t3_g1_paddr", {24'b0, paddr}, 32'h20);
    req = 2'b10;
    tick();
    chk("t3_g1_pen1", {31'b0, penable}, 32'h1);
    chk("t3_g1_psel", {31'b0, psel}, 32'h1);
    chk("t3_gap_ack", {30'b0, ack}, 32'h0);
    tick();
    chk("t3_ack1", {30'b0, ack}, 32'h2);
    chk("t3_rdata1", rdata, 32'hA5A50001);
    chk("t3_end_psel", {31'b0, psel}, 32'h0);
    req = 2'b00;
    tick();

    // One transfer by 0 moves the pointer to 1; the next pair then goes to 1 first
    req = 2'b01;
    tick();
    tick();
    tick();
    chk("t3_single_ack0", {30'b0, ack}, 32'h1);
    req = 2'b00;
    tick();
    req = 2'b11;
    tick();
    chk("t3_pair_first_paddr", {24'b0, paddr}, 32'h20);
    tick();
    tick();
    chk("t3_pair_first_ack", {30'b0, ack}, 32'h2);
    req = 2'b01;
    tick();
    tick();
    chk("t3_pair_second_ack", {30'b0, ack}, 32'h1);
    req = 2'b00;
    tick();

    // Status and unmapped reads by requester 0
    set_cmd(0, 1'b0, REG_STATUS, 32'h0);
    req = 2'b01;
    tick();
    tick();
    tick();
    chk("t4_status_ack", {30'b0, ack}, 32'h1);
    chk("t4_status_rdata", rdata, 32'hA5A50001);
    set_cmd(0, 1'b0, 8'h04, 32'h0);
    tick();
    tick();
    tick();
    chk("t4_unmapped_ack", {30'b0, ack}, 32'h1);
    chk("t4_unmapped_rdata", rdata, 32'h0);
    req = 2'b00;
    tick();

    // Reset during ACCESS of requester 1 (pointer is 1 beforehand)
    set_cmd(1, 1'b0, REG_CONTROL_1, 32'h0);
    req = 2'b10;
    tick();
    tick();
    chk("t5_in_access", {31'b0, penable}, 32'h1);
    #2;
    presetn = 1'b0;
    #1;
    chk("t5_rst_psel", {31'b0, psel}, 32'h0);
    chk("t5_rst_penable", {31'b0, penable}, 32'h0);
    chk("t5_rst_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("t5_rst_no_ack", {30'b0, ack}, 32'h0);
    presetn = 1'b1;
    set_cmd(0, 1'b0, REG_CONTROL_0, 32'h0);
    set_cmd(1, 1'b0, REG_STATUS, 32'h0);
    req = 2'b11;
    tick();
    chk("t5_ptr_zero_paddr", {24'b0, paddr}, 32'h00);
    tick();
    tick();
    chk("t5_ack0", {30'b0, ack}, 32'h1);
    req = 2'b10;
    tick();
    tick();
    chk("t5_reissue_ack1", {30'b0, ack}, 32'h2);
    chk("t5_reissue_rdata", rdata, 32'hA5A50001);
    req = 2'b00;
    tick();

    // Short pulse on req[1] while 0 is served; late address change ignored
    set_cmd(0, 1'b0, REG_CONTROL_0, 32'h0);
    req = 2'b01;
    tick();
    req = 2'b11;
    set_cmd(0, 1'b0, 8'h04, 32'h0);
    tick();
    req = 2'b01;
    chk("t6_paddr_stable", {24'b0, paddr}, 32'h00);
    tick();
    chk("t6_only_ack0", {30'b0, ack}, 32'h1);
    chk("t6_rdata", rdata, 32'hDEADBEEF);
    chk("t6_idle_psel", {31'b0, psel}, 32'h0);
    req = 2'b00;
    tick();
    chk("t6_no_ack1", {30'b0, ack}, 32'h0);
    chk("t6_idle_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("t6_still_idle", {31'b0, psel}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
